score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 166 ++++++++++++++++
 tb/tb_score_keeper.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Pong score keeper: edge-detects misses, scores points, holds the serve after a goal, detects the match win.
// Latency: one BALL_CLOCK from the registered miss edge to the score/pulse update; no backpressure, events outside PLAY are dropped.
// Optional feature macro SCORE_DEUCE_EN: win needs a two-point lead, ties at or above WIN_SCORE fold back to WIN_SCORE-1.
module score_keeper #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 32
) (
    input  logic       BALL_CLOCK,
    input  logic       RESET_N,
    input  logic       miss_player_1,
    input  logic       miss_player_2,
    input  logic       new_game,
    output logic       goal_player_1,
    output logic       goal_player_2,
    output logic       win_player_1,
    output logic       win_player_2,
    output logic [3:0] score_player_1,
    output logic [3:0] score_player_2,
    output logic       serve_enable,
    output logic       game_over
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [3:0] DEUCE_VAL  = 4'(WIN_SCORE - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYCLES);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       miss1_q, miss1_prev;
    logic       miss2_q, miss2_prev;
    logic       miss1_evt, miss2_evt;
    logic [3:0] p1_inc, p2_inc;
    logic       p1_wins, p2_wins;
    logic       p1_ties, p2_ties;

    assign miss1_evt = miss1_q & ~miss1_prev;
    assign miss2_evt = miss2_q & ~miss2_prev;
    assign p1_inc    = score_player_1 + 4'd1;
    assign p2_inc    = score_player_2 + 4'd1;

    always_comb begin
        p1_wins = 1'b0;
        p2_wins = 1'b0;
        p1_ties = 1'b0;
        p2_ties = 1'b0;
`ifdef SCORE_DEUCE_EN
        // 5-bit compare so opponent+2 cannot wrap near the top of the 4-bit range
        p1_wins = (p1_inc >= WIN_VAL) && ({1'b0, p1_inc} >= ({1'b0, score_player_2} + 5'd2));
        p2_wins = (p2_inc >= WIN_VAL) && ({1'b0, p2_inc} >= ({1'b0, score_player_1} + 5'd2));
        p1_ties = (p1_inc == score_player_2) && (p1_inc >= WIN_VAL);
        p2_ties = (p2_inc == score_player_1) && (p2_inc >= WIN_VAL);
`else
        p1_wins = (p1_inc == WIN_VAL);
        p2_wins = (p2_inc == WIN_VAL);
`endif
    end

    always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= PLAY;
            hold_cnt       <= 8'd0;
            miss1_q        <= 1'b0;
            miss1_prev     <= 1'b0;
            miss2_q        <= 1'b0;
            miss2_prev     <= 1'b0;
            score_player_1 <= 4'd0;
            score_player_2 <= 4'd0;
            goal_player_1  <= 1'b0;
            goal_player_2  <= 1'b0;
            win_player_1   <= 1'b0;
            win_player_2   <= 1'b0;
            serve_enable   <= 1'b1;
            game_over      <= 1'b0;
        end else begin
            miss1_q       <= miss_player_1;
            miss1_prev    <= miss1_q;
            miss2_q       <= miss_player_2;
            miss2_prev    <= miss2_q;
            goal_player_1 <= 1'b0;
            goal_player_2 <= 1'b0;
            win_player_1  <= 1'b0;
            win_player_2  <= 1'b0;

            if (new_game) begin
                state          <= PLAY;
                hold_cnt       <= 8'd0;
                score_player_1 <= 4'd0;
                score_player_2 <= 4'd0;
                serve_enable   <= 1'b1;
                game_over      <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        // a miss on both sides in one cycle is a dead ball
                        if (miss2_evt && !miss1_evt) begin
                            if (p1_wins) begin
                                score_player_1 <= p1_inc;
                                win_player_1   <= 1'b1;
                                state          <= OVER;
                                serve_enable   <= 1'b0;
                                game_over      <= 1'b1;
                            end else begin
                                if (p1_ties) begin
                                    score_player_1 <= DEUCE_VAL;
                                    score_player_2 <= DEUCE_VAL;
                                end else begin
                                    score_player_1 <= p1_inc;
                                end
                                goal_player_1 <= 1'b1;
                                hold_cnt      <= HOLD_INIT;
                                state         <= HOLD;
                                serve_enable  <= 1'b0;
                            end
                        end else if (miss1_evt && !miss2_evt) begin
                            if (p2_wins) begin
                                score_player_2 <= p2_inc;
                                win_player_2   <= 1'b1;
                                state          <= OVER;
                                serve_enable   <= 1'b0;
                                game_over      <= 1'b1;
                            end else begin
                                if (p2_ties) begin
                                    score_player_1 <= DEUCE_VAL;
                                    score_player_2 <= DEUCE_VAL;
                                end else begin
                                    score_player_2 <= p2_inc;
                                end
                                goal_player_2 <= 1'b1;
                                hold_cnt      <= HOLD_INIT;
                                state         <= HOLD;
                                serve_enable  <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        // the edge that takes the counter to zero is the edge that re-enables the serve
                        if (hold_cnt <= 8'd1) begin
                            hold_cnt     <= 8'd0;
                            state        <= PLAY;
                            serve_enable <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    OVER: begin
                        serve_enable <= 1'b0;
                        game_over    <= 1'b1;
                    end
                    default: begin
                        state        <= PLAY;
                        hold_cnt     <= 8'd0;
                        serve_enable <= 1'b1;
                        game_over    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with default parameters (WIN_SCORE=7, HOLD_CYCLES=32).
module tb_score_keeper;

    logic       clk;
    logic       rst_n;
    logic       miss_player_1, miss_player_2, new_game;
    logic       goal_player_1, goal_player_2, win_player_1, win_player_2;
    logic [3:0] score_player_1, score_player_2;
    logic       serve_enable, game_over;

    int total = 0;
    int bad   = 0;

    score_keeper dut (
        .BALL_CLOCK     (clk),
        .RESET_N        (rst_n),
        .miss_player_1  (miss_player_1),
        .miss_player_2  (miss_player_2),
        .new_game       (new_game),
        .goal_player_1  (goal_player_1),
        .goal_player_2  (goal_player_2),
        .win_player_1   (win_player_1),
        .win_player_2   (win_player_2),
        .score_player_1 (score_player_1),
        .score_player_2 (score_player_2),
        .serve_enable   (serve_enable),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {goal_player_1, goal_player_2, win_player_1, win_player_2};
    endfunction

    // Raise one miss line, sample the pulse two edges later, then count serve-low cycles (bounded).
    task automatic do_miss(input int p, output logic [3:0] pul, output logic [3:0] pul_next, output int low);
        if (p == 1) miss_player_1 = 1'b1;
        else        miss_player_2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pul = pulses();
        miss_player_1 = 1'b0;
        miss_player_2 = 1'b0;
        low = serve_enable ? 0 : 1;
        @(negedge clk);
        pul_next = pulses();
        while (!serve_enable && !game_over && low < 300) begin
            low++;
            @(negedge clk);
        end
    endtask

    logic [3:0] pul, pnx;
    int low, n, g, w, extra;

    initial begin
        rst_n = 1'b0;
        miss_player_1 = 1'b0;
        miss_player_2 = 1'b0;
        new_game = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_score1", score_player_1, 0);
        check_val("rst_score2", score_player_2, 0);
        check_val("rst_pulses", pulses(), 0);
        check_val("rst_serve", serve_enable, 1);
        check_val("rst_over", game_over, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // first point for player 1, then the 32-cycle serve hold
        do_miss(2, pul, pnx, low);
        check_val("p1_goal_pulse", pul, 4'b1000);
        check_val("p1_goal_width", pnx, 0);
        check_val("p1_score1", score_player_1, 1);
        check_val("p1_score2", score_player_2, 0);
        check_val("hold_len", low, 32);
        check_val("serve_back", serve_enable, 1);

        // held miss level scores once
        n = 0;
        miss_player_1 = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (goal_player_2) n++;
        end
        miss_player_1 = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (goal_player_2) n++;
        end
        check_val("held_goals", n, 1);
        check_val("held_score2", score_player_2, 1);
        check_val("held_serve", serve_enable, 1);

        // simultaneous misses are ignored
        n = 0;
        miss_player_1 = 1'b1;
        miss_player_2 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (pulses() != 0) n++;
        end
        miss_player_1 = 1'b0;
        miss_player_2 = 1'b0;
        @(negedge clk);
        check_val("both_pulses", n, 0);
        check_val("both_score1", score_player_1, 1);
        check_val("both_score2", score_player_2, 1);
        check_val("both_serve", serve_enable, 1);

        // new_game wins over a miss that rises with it
        n = 0;
        new_game = 1'b1;
        miss_player_2 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (pulses() != 0) n++;
        end
        new_game = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (pulses() != 0) n++;
        end
        miss_player_2 = 1'b0;
        @(negedge clk);
        check_val("ng_prio_pulses", n, 0);
        check_val("ng_prio_score1", score_player_1, 0);
        check_val("ng_prio_score2", score_player_2, 0);

        // seven straight player-1 points
        g = 0; w = 0; extra = 0;
        for (int i = 0; i < 7; i++) begin
            do_miss(2, pul, pnx, low);
            g += int'(pul[3]);
            w += int'(pul[1]);
            if (pnx != 0) extra++;
            if (i < 6) check_val("run_goal", pul, 4'b1000);
        end
        check_val("win_pulse", pul, 4'b0010);
        check_val("run_goals", g, 6);
        check_val("run_wins", w, 1);
        check_val("run_wide_pulse", extra, 0);
        check_val("win_score1", score_player_1, 7);
        check_val("win_over", game_over, 1);
        check_val("win_serve", serve_enable, 0);

        // misses are frozen out in OVER
        do_miss(1, pul, pnx, low);
        check_val("over_pulse", pul, 0);
        check_val("over_score2", score_player_2, 0);
        check_val("over_score1", score_player_1, 7);

        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_val("ng_score1", score_player_1, 0);
        check_val("ng_score2", score_player_2, 0);
        check_val("ng_serve", serve_enable, 1);
        check_val("ng_over", game_over, 0);

        // reset in the middle of a hold
        miss_player_1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_goal2", pulses(), 4'b0100);
        miss_player_1 = 1'b0;
        repeat (9) @(negedge clk);
        check_val("mid_hold_serve", serve_enable, 0);
        rst_n = 1'b0;
        #1;
        check_val("arst_score2", score_player_2, 0);
        check_val("arst_serve", serve_enable, 1);
        check_val("arst_over", game_over, 0);
        check_val("arst_pulses", pulses(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_serve", serve_enable, 1);
        check_val("post_rst_pulses", pulses(), 0);

`ifdef SCORE_DEUCE_EN
        for (int i = 0; i < 6; i++) do_miss(2, pul, pnx, low);
        for (int i = 0; i < 6; i++) do_miss(1, pul, pnx, low);
        do_miss(2, pul, pnx, low);
        check_val("deuce_7_6", {score_player_1, score_player_2}, 8'h76);
        do_miss(1, pul, pnx, low);
        check_val("deuce_fold_pulse", pul, 4'b0100);
        check_val("deuce_fold", {score_player_1, score_player_2}, 8'h66);
        do_miss(2, pul, pnx, low);
        check_val("deuce_adv_pulse", pul, 4'b1000);
        do_miss(2, pul, pnx, low);
        check_val("deuce_win_pulse", pul, 4'b0010);
        check_val("deuce_win_score", {score_player_1, score_player_2}, 8'h86);
        check_val("deuce_over", game_over, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
